// File: rtl/ahb_pkg.sv
// Shared AHB-Lite encodings and the control bundle the arbiter muxes between masters.
// Latency: n/a (types, constants and a pure helper function only).
// Backpressure: n/a.
package ahb_pkg;

    localparam logic [1:0] HTRANS_IDLE   = 2'b00;
    localparam logic [1:0] HTRANS_BUSY   = 2'b01;
    localparam logic [1:0] HTRANS_NONSEQ = 2'b10;
    localparam logic [1:0] HTRANS_SEQ    = 2'b11;

    localparam logic [2:0] HBURST_SINGLE = 3'b000;

    // Address-phase control of one master, kept together so it can be muxed as one word.
    typedef struct packed {
        logic [1:0] htrans;
        logic       hwrite;
        logic [2:0] hsize;
        logic [2:0] hburst;
    } ahb_ctrl_t;

    // A master is asking for the bus only with a real transfer; IDLE and BUSY are not requests.
    function automatic logic is_req(input logic [1:0] htrans);
        return (htrans == HTRANS_NONSEQ) || (htrans == HTRANS_SEQ);
    endfunction

endpackage

// File: rtl/rr_arb2.sv
// Two-input round-robin arbiter with a lock that pins the grant on the current owner.
// Latency: combinational, zero cycles.
// Backpressure: none internally; the caller decides when the result is used.
//
// Ports: req[1:0] requests, last = most recently granted master, lock = hold cur,
//        cur = current address-phase owner, gnt = selected master.
module rr_arb2 (
    input  logic [1:0] req,
    input  logic       last,
    input  logic       lock,
    input  logic       cur,
    output logic       gnt
);

    always_comb begin
        gnt = cur;
        if (!lock) begin
            case (req)
                2'b01:   gnt = 1'b0;
                2'b10:   gnt = 1'b1;
                2'b11:   gnt = ~last;
                default: gnt = cur;   // nobody asking: park on the current owner
            endcase
        end
    end

endmodule

// File: rtl/ahb_arb2.sv
// Two-master AHB-Lite arbiter and bus mux: round-robin address grant, burst lock, held data-phase responses.
// Latency: zero cycles for an uncontested request; a contested loser waits at most one burst of the other master.
// Backpressure: slave wait states (s_hreadyout_i=0) freeze all state; a master that loses arbitration sees hready=0.
//
// Ports: hclk/hreset (sync, active-high); m0_*/m1_* AHB-Lite master-side inputs with hready/hresp/hrdata returns;
//        s_* muxed address/control/write data to the decoder, s_hready_o broadcast ready, s_hreadyout_i/s_hresp_i/
//        s_hrdata_i muxed slave response.
module ahb_arb2
    import ahb_pkg::*;
#(
    parameter int AWIDTH = 32,
    parameter int DWIDTH = 32
) (
    input  logic              hclk,
    input  logic              hreset,

    input  logic [1:0]        m0_htrans_i,
    input  logic              m0_hwrite_i,
    input  logic [2:0]        m0_hsize_i,
    input  logic [2:0]        m0_hburst_i,
    input  logic [AWIDTH-1:0] m0_haddr_i,
    input  logic [DWIDTH-1:0] m0_hwdata_i,
    output logic              m0_hready_o,
    output logic              m0_hresp_o,
    output logic [DWIDTH-1:0] m0_hrdata_o,

    input  logic [1:0]        m1_htrans_i,
    input  logic              m1_hwrite_i,
    input  logic [2:0]        m1_hsize_i,
    input  logic [2:0]        m1_hburst_i,
    input  logic [AWIDTH-1:0] m1_haddr_i,
    input  logic [DWIDTH-1:0] m1_hwdata_i,
    output logic              m1_hready_o,
    output logic              m1_hresp_o,
    output logic [DWIDTH-1:0] m1_hrdata_o,

    output logic [1:0]        s_htrans_o,
    output logic              s_hwrite_o,
    output logic [2:0]        s_hsize_o,
    output logic [2:0]        s_hburst_o,
    output logic [AWIDTH-1:0] s_haddr_o,
    output logic [DWIDTH-1:0] s_hwdata_o,
    output logic              s_hready_o,
    input  logic              s_hreadyout_i,
    input  logic              s_hresp_i,
    input  logic [DWIDTH-1:0] s_hrdata_i
);

    ahb_ctrl_t         ctrl   [2];
    logic [AWIDTH-1:0] haddr  [2];
    logic [DWIDTH-1:0] hwdata [2];
    logic [1:0]        req;

    assign ctrl[0]   = '{htrans: m0_htrans_i, hwrite: m0_hwrite_i, hsize: m0_hsize_i, hburst: m0_hburst_i};
    assign ctrl[1]   = '{htrans: m1_htrans_i, hwrite: m1_hwrite_i, hsize: m1_hsize_i, hburst: m1_hburst_i};
    assign haddr[0]  = m0_haddr_i;
    assign haddr[1]  = m1_haddr_i;
    assign hwdata[0] = m0_hwdata_i;
    assign hwdata[1] = m1_hwdata_i;
    assign req[0]    = is_req(m0_htrans_i);
    assign req[1]    = is_req(m1_htrans_i);

    // State
    logic              addr_own_q, addr_own_d;
    logic              data_own_q, data_own_d;
    logic              data_vld_q, data_vld_d;
    logic              last_q,     last_d;
    logic              lock_q,     lock_d;
    logic [1:0]        held_q,     held_d;
    logic [1:0]        hold_resp_q, hold_resp_d;
    logic [DWIDTH-1:0] hold_rdata_q [2];
    logic [DWIDTH-1:0] hold_rdata_d [2];

    // A running burst ends the moment its owner goes IDLE or starts a SINGLE, so the
    // other master can be granted on that same cycle instead of one cycle later.
    logic [1:0] own_htrans;
    logic [2:0] own_hburst;
    logic       lock_eff;

    assign own_htrans = ctrl[addr_own_q].htrans;
    assign own_hburst = ctrl[addr_own_q].hburst;
    assign lock_eff   = lock_q &&
                        !((own_htrans == HTRANS_IDLE) ||
                          ((own_htrans == HTRANS_NONSEQ) && (own_hburst == HBURST_SINGLE)));

    logic arb_gnt;
    logic grant;

    rr_arb2 u_arb (
        .req  (req),
        .last (last_q),
        .lock (lock_eff),
        .cur  (addr_own_q),
        .gnt  (arb_gnt)
    );

    // No re-arbitration during a slave wait state: the address phase on the bus must not change.
    assign grant = s_hreadyout_i ? arb_gnt : addr_own_q;

    // Per-master ready. A stalled loser is held off even while its own data phase completes;
    // that response is parked in hold_* and handed over when it is finally let through.
    logic [1:0] rdy;

    always_comb begin
        rdy = 2'b11;
        for (int n = 0; n < 2; n++) begin
            if (req[n] && (grant != 1'(n)))       rdy[n] = 1'b0;
            else if (held_q[n])                   rdy[n] = s_hreadyout_i;
            else if (data_own_q == 1'(n))         rdy[n] = s_hreadyout_i;
            else                                  rdy[n] = 1'b1;
        end
    end

    // Slave side. BUSY from a locked owner is forwarded; a parked grant with no request shows IDLE.
    assign s_htrans_o = (!hreset && (req[grant] || lock_eff)) ? ctrl[grant].htrans : HTRANS_IDLE;
    assign s_hwrite_o = ctrl[grant].hwrite;
    assign s_hsize_o  = ctrl[grant].hsize;
    assign s_hburst_o = ctrl[grant].hburst;
    assign s_haddr_o  = haddr[grant];
    assign s_hwdata_o = hwdata[data_own_q];
    assign s_hready_o = s_hreadyout_i;

    // Master side; outputs show their idle values while reset is applied.
    assign m0_hready_o = hreset | rdy[0];
    assign m1_hready_o = hreset | rdy[1];
    assign m0_hresp_o  = !hreset && (held_q[0] ? hold_resp_q[0] : s_hresp_i);
    assign m1_hresp_o  = !hreset && (held_q[1] ? hold_resp_q[1] : s_hresp_i);
    assign m0_hrdata_o = hreset ? '0 : (held_q[0] ? hold_rdata_q[0] : s_hrdata_i);
    assign m1_hrdata_o = hreset ? '0 : (held_q[1] ? hold_rdata_q[1] : s_hrdata_i);

    always_comb begin
        addr_own_d  = addr_own_q;
        data_own_d  = data_own_q;
        data_vld_d  = data_vld_q;
        last_d      = last_q;
        lock_d      = lock_q;
        held_d      = held_q;
        hold_resp_d = hold_resp_q;
        for (int n = 0; n < 2; n++) begin
            hold_rdata_d[n] = hold_rdata_q[n];
        end

        if (s_hreadyout_i) begin
            addr_own_d = grant;
            data_own_d = grant;
            data_vld_d = req[grant];
            if (req[grant]) begin
                last_d = grant;
            end
            lock_d = (req[grant] && (ctrl[grant].hburst != HBURST_SINGLE)) || lock_eff;

            for (int n = 0; n < 2; n++) begin
                if (data_vld_q && (data_own_q == 1'(n)) && !rdy[n]) begin
                    // Owner's data phase completes while it is stalled by the other master.
                    held_d[n]       = 1'b1;
                    hold_rdata_d[n] = s_hrdata_i;
                    hold_resp_d[n]  = s_hresp_i;
                end else if (rdy[n]) begin
                    held_d[n] = 1'b0;
                end
            end
        end
    end

    always_ff @(posedge hclk) begin
        if (hreset) begin
            addr_own_q  <= 1'b0;
            data_own_q  <= 1'b0;
            data_vld_q  <= 1'b0;
            last_q      <= 1'b0;
            lock_q      <= 1'b0;
            held_q      <= 2'b00;
            hold_resp_q <= 2'b00;
            for (int n = 0; n < 2; n++) begin
                hold_rdata_q[n] <= '0;
            end
        end else begin
            addr_own_q  <= addr_own_d;
            data_own_q  <= data_own_d;
            data_vld_q  <= data_vld_d;
            last_q      <= last_d;
            lock_q      <= lock_d;
            held_q      <= held_d;
            hold_resp_q <= hold_resp_d;
            for (int n = 0; n < 2; n++) begin
                hold_rdata_q[n] <= hold_rdata_d[n];
            end
        end
    end

endmodule

// File: doc/ahb_arb2.md
# ahb_arb2

Two-master AHB-Lite arbiter and bus multiplexer in front of the peripheral bus (GPIO, timer, UART slaves). Master 0 is the core LSU and master 1 is the debug/DMA port. The block presents one AHB-Lite master interface to the decoder and slaves. It grants address phases round-robin and holds a burst's grant until the burst ends. A master that loses arbitration is stalled without losing its completed data-phase response.

## Interface
Parameters:
- AWIDTH, 32, address width
- DWIDTH, 32, data width

Ports:
- Clock and reset: one clock; reset is synchronous and active-high.
  - hclk  in  1  bus clock
  - hreset  in  1  reset
- Master n, for n = 0 and 1:
  - mn_htrans_i  in  2  transfer type
  - mn_hwrite_i  in  1  write enable
  - mn_hsize_i  in  3  transfer size
  - mn_hburst_i  in  3  burst type
  - mn_haddr_i  in  AWIDTH  address
  - mn_hwdata_i  in  DWIDTH  write data
  - mn_hready_o  out  1  ready returned to master n
  - mn_hresp_o  out  1  response returned to master n
  - mn_hrdata_o  out  DWIDTH  read data returned to master n
- Slave side:
  - s_htrans_o, s_hwrite_o, s_hsize_o, s_hburst_o, s_haddr_o, s_hwdata_o  out  muxed address/control and write data
  - s_hready_o  out  1  bus hready fed to every slave's hready_i
  - s_hreadyout_i  in  1  muxed slave readyout
  - s_hresp_i  in  1  muxed slave response
  - s_hrdata_i  in  DWIDTH  muxed slave read data

## Operation
- Request: a master requests when its htrans is NONSEQ (2'b10) or SEQ (2'b11).
- Registers:
  - addr_own, 1 bit: the master that owns the address phase.
  - data_own, 1 bit: the master that owns the data phase.
  - data_vld: the data phase carries a real transfer.
  - last, 1 bit: the master granted most recently.
  - lock: a burst is in progress.
  - held[1:0]: per-master held-response flag.
  - hold_rdata[n]: held read data for master n.
  - hold_resp[n]: held response for master n.
- Arbitration is combinational. It is evaluated only when s_hreadyout_i=1.
  - If lock=1, the grant stays at addr_own.
  - Otherwise, if only one master requests, that master is granted.
  - If both request, the master not equal to last is granted.
  - If neither requests, the grant parks on addr_own and s_htrans_o is driven to IDLE.
- Lock handling:
  - lock sets when a granted transfer has hburst≠SINGLE.
  - lock clears when the owner drives IDLE or NONSEQ with hburst=SINGLE.
  - If the owner drives BUSY while lock=1, BUSY is forwarded and the grant is held.
- Slave-side mux:
  - Address/control outputs come from the granted master.
  - s_hwdata_o comes from data_own.
  - s_hready_o = s_hreadyout_i.
- Register update on a cycle with s_hreadyout_i=1:
  - data_own <= grant.
  - data_vld <= the granted master was requesting.
  - last <= grant, if that master was requesting.
- mn_hready_o, evaluated in this order:
  - If master n requests and is not granted: 0.
  - Else if held[n]=1: s_hreadyout_i.
  - Else if master n is data_own: s_hreadyout_i.
  - Else: 1.
- Held-response path:
  - Trigger: s_hreadyout_i=1, data_vld=1, data_own=n, and mn_hready_o=0 (master n lost arbitration).
  - Action: hold_rdata[n] <= s_hrdata_i, hold_resp[n] <= s_hresp_i, held[n] <= 1.
  - While held[n]=1, master n reads hold_rdata[n] and hold_resp[n].
  - held[n] clears on the first cycle with mn_hready_o=1.
- Otherwise mn_hrdata_o and mn_hresp_o are the pass-through of s_hrdata_i and s_hresp_i.
- Slave responses: slaves return OKAY only; hresp is passed through or held as a single bit.

## Timing
- Reset values:
  - addr_own, data_own, last, data_vld, lock, held: all 0.
  - s_htrans_o: IDLE.
  - mn_hready_o: 1.
  - mn_hresp_o: 0.
  - mn_hrdata_o: 0.
- Arbitration latency:
  - Zero cycles for an uncontested NONSEQ.
  - A contested loser waits at least one transfer, but no more than one burst of the other master.
- Slave wait states: while s_hreadyout_i=0, grant, data_own and all held flags freeze, and no new grant is made.
- Simultaneous events:
  - Both masters request in the same cycle after reset: master 1 wins, because last=0.
  - A held response is captured and a new grant is made in the same cycle.
- Reset mid-transfer: all state is cleared, and any held response is discarded.

## Structure
- Shared package ahb_pkg: HTRANS_IDLE, HTRANS_BUSY, HTRANS_NONSEQ, HTRANS_SEQ, HBURST_SINGLE.
- Sub-module rr_arb2: the two-input round-robin arbiter with lock input.
  - Inputs: req[1:0], last, lock, cur.
  - Output: gnt.

## Test plan
- Only m0 requests: single write of 0x3 to 0x4 (GPIO_CTRL), then a read of 0x4.
  - Required: zero stall cycles, m0_hrdata_o=0x3, m1_hready_o=1 throughout.
- Both masters NONSEQ on the first cycle after reset.
  - Required: m1 granted first, m0_hready_o=0 for one cycle, then m0 granted; last toggles 1→0.
- m1 runs an INCR4 burst while m0 requests.
  - Required: m0 is stalled for all 4 beats; m0 is granted on the beat after the final SEQ.
- m0 reads 0x0 (rdata 0xA5) back-to-back with a new request while m1 also requests.
  - Required: 0xA5 is captured in hold_rdata[0]; m0 later sees hready=1 with m0_hrdata_o=0xA5.
- Slave inserts 3 wait states during an m1 write.
  - Required: s_hwdata_o is stable, no grant change, and both hready outputs track the slave wait.
- hreset asserted while m0 is stalled and holding a response.
  - Required: the next cycle shows held=0, s_htrans_o=IDLE, and both mn_hready_o=1.
